// File: rtl/mips32_pkg.sv
// mips32_pkg: shared definitions for the pipe_mips32 core.
//   - opcode constants of the reduced MIPS32-like ISA
//   - instruction-type enum used by every pipeline stage
//   - packed pipeline-register structs (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   - decode_type(): opcode -> instruction type
package mips32_pkg;

    localparam int MEM_DEPTH = 1024;
    localparam int NUM_REGS  = 32;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_SLT   = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h08;
    localparam logic [5:0] OP_SW    = 6'h09;
    localparam logic [5:0] OP_ADDI  = 6'h0A;
    localparam logic [5:0] OP_SUBI  = 6'h0B;
    localparam logic [5:0] OP_SLTI  = 6'h0C;
    localparam logic [5:0] OP_BNEQZ = 6'h0D;
    localparam logic [5:0] OP_BEQZ  = 6'h0E;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    typedef enum logic [2:0] {
        RR_ALU,
        RM_ALU,
        LOAD,
        STORE,
        BRANCH,
        HALT,
        NOP
    } itype_e;

    typedef struct packed {
        logic        valid;
        itype_e      itype;
        logic [31:0] ir;
        logic [31:0] npc;
    } ifid_t;

    typedef struct packed {
        logic        valid;
        itype_e      itype;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
        logic [4:0]  dst;
        logic        we;
    } idex_t;

    typedef struct packed {
        logic        valid;
        itype_e      itype;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  dst;
        logic        we;
    } exmem_t;

    typedef struct packed {
        logic        valid;
        itype_e      itype;
        logic [31:0] result;
        logic [4:0]  dst;
        logic        we;
    } memwb_t;

    function automatic itype_e decode_type(input logic [5:0] op);
        itype_e t;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
            OP_LW:                                         t = LOAD;
            OP_SW:                                         t = STORE;
            OP_BNEQZ, OP_BEQZ:                             t = BRANCH;
            OP_HLT:                                        t = HALT;
            default:                                       t = NOP;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips32_alu.sv
// mips32_alu: combinational ALU of the pipe_mips32 core.
// Ports:
//   op_i     [5:0]  operation, encoded with the register-register opcodes
//   a_i      [31:0] first operand
//   b_i      [31:0] second operand
//   result_o [31:0] result (SLT is signed, MUL keeps the low 32 bits)
//   zero_o          result == 0
module mips32_alu
    import mips32_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_SLT:  result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
            OP_MUL:  result_o = a_i * b_i;
            default: result_o = '0;
        endcase
        zero_o = (result_o == 32'd0);
    end

endmodule

// File: rtl/pipe_mips32.sv
// pipe_mips32: five-stage (IF, ID, EX, MEM, WB) in-order MIPS32-like core.
// Holds a 32x32 register file (Reg) and a unified 1024x32 word-addressed
// memory (Mem); both are preloaded and inspected hierarchically.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset (clears PC, HALTED, TAKEN_BRANCH
//           and every pipeline valid bit; Reg and Mem are kept)
//   halted  copy of HALTED, set when HLT retires in WB
module pipe_mips32
    import mips32_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic halted
);

    logic [31:0] Reg [0:NUM_REGS-1];
    logic [31:0] Mem [0:MEM_DEPTH-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    logic        fetch_stop_q;
    logic [31:0] pc_d;
    ifid_t       ifid_q, ifid_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;

    // ---- MEM stage result, also the source of the MEM bypass ----
    logic [31:0] mem_result;
    logic        mem_fwd;
    logic        wb_we;

    assign mem_result = (exmem_q.itype == LOAD) ? Mem[exmem_q.alu[9:0]] : exmem_q.alu;
    assign mem_fwd    = exmem_q.valid && exmem_q.we && (exmem_q.dst != 5'd0);
    assign wb_we      = memwb_q.valid && memwb_q.we && (memwb_q.dst != 5'd0);

    // ---- EX: ALU, branch resolution ----
    logic [5:0]  alu_op;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        ex_taken;
    logic [31:0] ex_target;

    always_comb begin
        alu_op = OP_ADD;
        alu_b  = idex_q.b;
        case (idex_q.itype)
            RR_ALU: alu_op = idex_q.op;
            RM_ALU: begin
                alu_b = idex_q.imm;
                case (idex_q.op)
                    OP_SUBI: alu_op = OP_SUB;
                    OP_SLTI: alu_op = OP_SLT;
                    default: alu_op = OP_ADD;
                endcase
            end
            LOAD, STORE: alu_b = idex_q.imm;
            // A + 0 makes the zero flag test Reg[rs] directly.
            BRANCH:  alu_b = '0;
            default: alu_b = idex_q.b;
        endcase
    end

    mips32_alu u_alu (
        .op_i     (alu_op),
        .a_i      (idex_q.a),
        .b_i      (alu_b),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    assign ex_taken  = idex_q.valid && (idex_q.itype == BRANCH) &&
                       ((idex_q.op == OP_BEQZ) ? alu_zero : !alu_zero);
    assign ex_target = idex_q.npc + idex_q.imm;

    // ---- ID: decode and operand read with MEM bypass and WB write-through ----
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_a, id_b, id_imm;
    logic        id_is_hlt;

    assign id_rs     = ifid_q.ir[25:21];
    assign id_rt     = ifid_q.ir[20:16];
    assign id_rd     = ifid_q.ir[15:11];
    assign id_imm    = {{16{ifid_q.ir[15]}}, ifid_q.ir[15:0]};
    assign id_is_hlt = ifid_q.valid && (ifid_q.itype == HALT);

    // The MEM-stage producer is younger than the WB one, so it wins.
    always_comb begin
        id_a = Reg[id_rs];
        if (id_rs == 5'd0)                              id_a = '0;
        else if (mem_fwd && (exmem_q.dst == id_rs))     id_a = mem_result;
        else if (wb_we && (memwb_q.dst == id_rs))       id_a = memwb_q.result;

        id_b = Reg[id_rt];
        if (id_rt == 5'd0)                              id_b = '0;
        else if (mem_fwd && (exmem_q.dst == id_rt))     id_b = mem_result;
        else if (wb_we && (memwb_q.dst == id_rt))       id_b = memwb_q.result;
    end

    always_comb begin
        idex_d.valid = ifid_q.valid && !ex_taken;
        idex_d.itype = ifid_q.itype;
        idex_d.op    = ifid_q.ir[31:26];
        idex_d.a     = id_a;
        idex_d.b     = id_b;
        idex_d.imm   = id_imm;
        idex_d.npc   = ifid_q.npc;
        idex_d.dst   = (ifid_q.itype == RR_ALU) ? id_rd : id_rt;
        idex_d.we    = (ifid_q.itype == RR_ALU) || (ifid_q.itype == RM_ALU) ||
                       (ifid_q.itype == LOAD);
    end

    // ---- IF: fetch, redirect on taken branch, stop once HLT is decoded ----
    always_comb begin
        ifid_d.valid = 1'b0;
        ifid_d.ir    = Mem[PC[9:0]];
        ifid_d.itype = decode_type(ifid_d.ir[31:26]);
        ifid_d.npc   = PC + 32'd1;
        pc_d         = PC;
        if (ex_taken) begin
            pc_d = ex_target;
        end else if (!fetch_stop_q && !id_is_hlt) begin
            ifid_d.valid = 1'b1;
            pc_d         = PC + 32'd1;
        end
    end

    always_comb begin
        exmem_d.valid = idex_q.valid;
        exmem_d.itype = idex_q.itype;
        exmem_d.alu   = alu_res;
        exmem_d.b     = idex_q.b;
        exmem_d.dst   = idex_q.dst;
        exmem_d.we    = idex_q.we;

        memwb_d.valid  = exmem_q.valid;
        memwb_d.itype  = exmem_q.itype;
        memwb_d.result = mem_result;
        memwb_d.dst    = exmem_q.dst;
        memwb_d.we     = exmem_q.we;
    end

    // ---- stage registers; everything freezes once HALTED is set ----
    always_ff @(posedge clk) begin
        if (rst) begin
            PC            <= '0;
            HALTED        <= 1'b0;
            TAKEN_BRANCH  <= 1'b0;
            fetch_stop_q  <= 1'b0;
            ifid_q.valid  <= 1'b0;
            idex_q.valid  <= 1'b0;
            exmem_q.valid <= 1'b0;
            memwb_q.valid <= 1'b0;
        end else if (!HALTED) begin
            PC           <= pc_d;
            TAKEN_BRANCH <= ex_taken;
            // A HLT on the wrong path of a taken branch must not stop fetch.
            if (id_is_hlt && !ex_taken)
                fetch_stop_q <= 1'b1;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            if (memwb_q.valid && (memwb_q.itype == HALT))
                HALTED <= 1'b1;
        end
    end

    // ---- architectural writes: WB to Reg, MEM stores to Mem ----
    always_ff @(posedge clk) begin
        if (!rst && !HALTED) begin
            if (wb_we)
                Reg[memwb_q.dst] <= memwb_q.result;
            if (exmem_q.valid && (exmem_q.itype == STORE))
                Mem[exmem_q.alu[9:0]] <= exmem_q.b;
        end
    end

    assign halted = HALTED;

endmodule

// File: tb/tb_pipe_mips32.sv
module tb_pipe_mips32;
    import mips32_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;

    pipe_mips32 dut (
        .clk    (clk),
        .rst    (rst),
        .halted (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int taken_cnt;

    // Preload image (also the starting state of the reference model)
    logic [31:0] mreg [32];
    logic [31:0] mmem [1024];
    // Reference-model end state
    logic [31:0] exp_reg [32];
    logic [31:0] exp_mem [1024];
    logic [31:0] prog [$];

    localparam logic [31:0] NOPI = 32'h4000_0000;   // opcode 0x10, no effect
    localparam logic [31:0] HLTI = 32'hFC00_0000;

    typedef struct {
        logic [31:0] ins;
        int          dst;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_image();
        for (int i = 0; i < 1024; i++) mmem[i] = '0;
        for (int r = 0; r < 32; r++) mreg[r] = 32'(r);
    endtask

    task automatic place_prog();
        for (int i = 0; i < prog.size(); i++) mmem[i] = prog[i];
    endtask

    // Core is held in reset here, so it does not touch Reg/Mem meanwhile.
    task automatic push_image();
        for (int i = 0; i < 1024; i++) dut.Mem[i] <= mmem[i];
        for (int r = 0; r < 32; r++) dut.Reg[r] <= mreg[r];
        #1;
    endtask

    task automatic run(input int budget, output int cyc);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        taken_cnt = 0;
        while (cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dut.TAKEN_BRANCH) taken_cnt++;
            if (halted) break;
        end
    endtask

    function automatic void set_reg(input int r, input logic [31:0] v);
        if (r != 0) exp_reg[r] = v;
    endfunction

    // Instruction-at-a-time interpreter of the ISA (no pipeline).
    task automatic iss();
        logic [31:0] pc, ir, a, b, imm, addr;
        logic [5:0]  op;
        int          rs, rt, rd;
        bit          done;
        for (int r = 0; r < 32; r++) exp_reg[r] = mreg[r];
        for (int i = 0; i < 1024; i++) exp_mem[i] = mmem[i];
        pc = 0;
        done = 0;
        for (int step = 0; step < 4000 && !done; step++) begin
            ir   = exp_mem[pc[9:0]];
            op   = ir[31:26];
            rs   = int'(ir[25:21]);
            rt   = int'(ir[20:16]);
            rd   = int'(ir[15:11]);
            a    = (rs == 0) ? 32'd0 : exp_reg[rs];
            b    = (rt == 0) ? 32'd0 : exp_reg[rt];
            imm  = {{16{ir[15]}}, ir[15:0]};
            addr = a + imm;
            pc   = pc + 1;
            case (op)
                OP_ADD:   set_reg(rd, a + b);
                OP_SUB:   set_reg(rd, a - b);
                OP_AND:   set_reg(rd, a & b);
                OP_OR:    set_reg(rd, a | b);
                OP_SLT:   set_reg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                OP_MUL:   set_reg(rd, a * b);
                OP_ADDI:  set_reg(rt, a + imm);
                OP_SUBI:  set_reg(rt, a - imm);
                OP_SLTI:  set_reg(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
                OP_LW:    set_reg(rt, exp_mem[addr[9:0]]);
                OP_SW:    exp_mem[addr[9:0]] = b;
                OP_BNEQZ: if (a != 0) pc = pc + imm;
                OP_BEQZ:  if (a == 0) pc = pc + imm;
                OP_HLT:   done = 1;
                default:  ;
            endcase
        end
    endtask

    task automatic gen_random_prog();
        int          br_idx [$];
        logic [5:0]  nop_ops [5];
        logic [5:0]  op;
        logic [31:0] t;
        int          kind, maxi, lim;
        nop_ops = '{6'h06, 6'h07, 6'h10, 6'h2A, 6'h3E};
        prog.delete();
        for (int i = 0; i < 20; i++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1, 2: prog.push_back(rr(6'($urandom_range(0, 5)), $urandom_range(0, 31),
                                           $urandom_range(0, 31), $urandom_range(0, 31)));
                3, 4: begin
                    case ($urandom_range(0, 2))
                        0:       op = OP_ADDI;
                        1:       op = OP_SUBI;
                        default: op = OP_SLTI;
                    endcase
                    prog.push_back(ri(op, $urandom_range(0, 31), $urandom_range(0, 31),
                                      $urandom_range(0, 65535)));
                end
                5: prog.push_back(ri(OP_LW, $urandom_range(0, 31), 0, 512 + $urandom_range(0, 63)));
                6: prog.push_back(ri(OP_SW, $urandom_range(0, 31), 0, 512 + $urandom_range(0, 63)));
                7: begin
                    br_idx.push_back(prog.size());
                    prog.push_back(ri(($urandom_range(0, 1) == 1) ? OP_BEQZ : OP_BNEQZ, 0,
                                      $urandom_range(0, 31), 0));
                end
                8: begin
                    t = $urandom;
                    t[31:26] = nop_ops[$urandom_range(0, 4)];
                    prog.push_back(t);
                end
                default: prog.push_back(ri(OP_ADDI, $urandom_range(0, 31), $urandom_range(0, 31),
                                           $urandom_range(0, 15)));
            endcase
            repeat ($urandom_range(1, 2)) prog.push_back(NOPI);
        end
        prog.push_back(HLTI);
        foreach (br_idx[k]) begin
            maxi = prog.size() - 1 - (br_idx[k] + 1);
            lim  = (maxi < 4) ? maxi : 4;
            t = prog[br_idx[k]];
            t[15:0] = 16'($urandom_range(0, lim));
            prog[br_idx[k]] = t;
        end
    endtask

    task automatic build_ls_prog();
        clear_image();
        prog = '{ri(OP_ADDI, 1, 0, 120), rr(OP_OR, 3, 3, 3), ri(OP_LW, 2, 1, 0),
                 rr(OP_OR, 3, 3, 3), ri(OP_ADDI, 2, 2, 45), rr(OP_OR, 3, 3, 3),
                 ri(OP_SW, 2, 1, 1), HLTI};
        place_prog();
        mmem[120] = 32'd85;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Reset state
        enter_reset();
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_pc", dut.PC, 32'd0);
        check("reset_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

        // Load/store program
        build_ls_prog();
        push_image();
        run(100, cyc);
        check("ls_halted", {31'd0, halted}, 32'd1);
        check("ls_halt_cycle", 32'(cyc), 32'd12);
        check("ls_mem121", dut.Mem[121], 32'd130);
        check("ls_mem120", dut.Mem[120], 32'd85);
        check("ls_r1", dut.Reg[1], 32'd120);
        check("ls_r2", dut.Reg[2], 32'd130);

        // Reset in the middle of the same program, then full rerun
        enter_reset();
        build_ls_prog();
        push_image();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_halted", {31'd0, halted}, 32'd0);
        check("midrst_pc", dut.PC, 32'd0);
        run(100, cyc);
        check("midrst_rerun_halted", {31'd0, halted}, 32'd1);
        check("midrst_rerun_cycle", 32'(cyc), 32'd12);
        check("midrst_mem121", dut.Mem[121], 32'd130);
        check("midrst_mem120", dut.Mem[120], 32'd85);
        check("midrst_r1", dut.Reg[1], 32'd120);
        check("midrst_r2", dut.Reg[2], 32'd130);

        // ALU vector table, Reg[k]=k at start
        tbl[0]  = '{rr(OP_ADD, 10, 1, 2),    10, 32'd3};
        tbl[1]  = '{rr(OP_SUB, 11, 1, 2),    11, 32'hFFFF_FFFF};
        tbl[2]  = '{rr(OP_MUL, 12, 5, 6),    12, 32'd30};
        tbl[3]  = '{rr(OP_SLT, 13, 11, 1),   13, 32'd1};
        tbl[4]  = '{rr(OP_AND, 14, 7, 3),    14, 32'd3};
        tbl[5]  = '{rr(OP_OR, 15, 8, 4),     15, 32'd12};
        tbl[6]  = '{rr(OP_SLT, 16, 1, 11),   16, 32'd0};
        tbl[7]  = '{ri(OP_ADDI, 17, 9, -4),  17, 32'd5};
        tbl[8]  = '{ri(OP_SUBI, 18, 9, 10),  18, 32'hFFFF_FFFF};
        tbl[9]  = '{ri(OP_SLTI, 19, 18, 0),  19, 32'd1};
        tbl[10] = '{ri(OP_ADDI, 0, 0, 5),    0,  32'd0};
        tbl[11] = '{rr(OP_MUL, 22, 11, 11),  22, 32'd1};
        tbl[12] = '{rr(6'h07, 23, 1, 2),     23, 32'd23};
        enter_reset();
        clear_image();
        prog.delete();
        for (int i = 0; i < 13; i++) begin
            prog.push_back(tbl[i].ins);
            prog.push_back(NOPI);
        end
        prog.push_back(HLTI);
        place_prog();
        push_image();
        run(200, cyc);
        check("alu_halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 13; i++)
            check($sformatf("alu_vec%0d_r%0d", i, tbl[i].dst), dut.Reg[tbl[i].dst], tbl[i].exp);

        // Branches: BEQZ R0 taken over two instructions, BNEQZ R0 falls through
        enter_reset();
        clear_image();
        prog = '{ri(OP_BEQZ, 0, 0, 2), ri(OP_ADDI, 20, 0, 1), ri(OP_ADDI, 21, 0, 1),
                 ri(OP_ADDI, 24, 0, 7), NOPI, ri(OP_BNEQZ, 0, 0, 2),
                 ri(OP_ADDI, 25, 0, 9), NOPI, HLTI};
        place_prog();
        push_image();
        run(100, cyc);
        check("br_halted", {31'd0, halted}, 32'd1);
        check("br_r20_skipped", dut.Reg[20], 32'd20);
        check("br_r21_skipped", dut.Reg[21], 32'd21);
        check("br_target_r24", dut.Reg[24], 32'd7);
        check("br_fallthru_r25", dut.Reg[25], 32'd9);
        check("br_taken_pulses", 32'(taken_cnt), 32'd1);
        check("br_halt_cycle", 32'(cyc), 32'd13);

        // Halt: SW after HLT is never executed, state frozen afterwards
        enter_reset();
        clear_image();
        prog = '{ri(OP_ADDI, 26, 0, 3), NOPI, HLTI, ri(OP_SW, 26, 0, 600)};
        place_prog();
        mmem[600] = 32'hDEAD_BEEF;
        push_image();
        run(100, cyc);
        check("hlt_halted", {31'd0, halted}, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("hlt_still_halted", {31'd0, halted}, 32'd1);
        check("hlt_pc_frozen", dut.PC, 32'd3);
        check("hlt_sw_blocked", dut.Mem[600], 32'hDEAD_BEEF);
        check("hlt_r26", dut.Reg[26], 32'd3);
        check("hlt_r27", dut.Reg[27], 32'd27);

        // Randomized programs against the ISA interpreter
        for (int p = 0; p < 6; p++) begin
            enter_reset();
            for (int i = 0; i < 1024; i++) mmem[i] = '0;
            for (int r = 0; r < 32; r++) mreg[r] = $urandom;
            for (int i = 512; i < 576; i++) mmem[i] = $urandom;
            if (p == 0) mreg[0] = '0;
            gen_random_prog();
            place_prog();
            iss();
            push_image();
            run(2000, cyc);
            check($sformatf("rnd%0d_halted", p), {31'd0, halted}, 32'd1);
            for (int r = 0; r < 32; r++)
                check($sformatf("rnd%0d_r%0d", p, r), dut.Reg[r], exp_reg[r]);
            for (int i = 512; i < 576; i++)
                check($sformatf("rnd%0d_mem%0d", p, i), dut.Mem[i], exp_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_mips32.md
# pipe_mips32

Five-stage, in-order, single-issue pipelined processor for a reduced MIPS32-like ISA: IF, ID, EX, MEM, WB. It holds a 32×32 register file and a unified 1024×32 word-addressed memory for instructions and data. It is a self-contained core for simulation. Programs and data are preloaded hierarchically, and results are read back hierarchically or through `halted`.

## Interface
- No parameters. Memory depth is fixed at 1024 words and register count at 32.
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `halted`  out  1  Copy of internal `HALTED`. Reset value 0.
- Hierarchically visible state, names fixed:
  - `Reg[0:31]` (32-bit).
  - `Mem[0:1023]` (32-bit).
  - `PC` (32-bit, word index).
  - `HALTED`.
  - `TAKEN_BRANCH`.
  - The bench may preload these after reset.

## Operation
- Encoding:
  - op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0], sign-extended to 32 bits.
  - RR ops write rd. Immediate ops and LW write rt.
- Opcodes:
  - RR ops: ADD 00, SUB 01, AND 02, OR 03, SLT 04 (signed, result 1/0), MUL 05 (low 32 bits).
  - LW 08: rt ← Mem[rs+imm].
  - SW 09: Mem[rs+imm] ← rt.
  - ADDI 0A, SUBI 0B, SLTI 0C (signed).
  - BNEQZ 0D: taken if Reg[rs]≠0. BEQZ 0E: taken if Reg[rs]=0. Target = branch PC + 1 + imm.
  - HLT 3F.
  - Any other opcode is a NOP: no register or memory write.
- Memory is word-addressed; only address bits [9:0] are used.
  - Reads are combinational.
  - Writes happen on the clock edge in MEM.
- R0 reads as 0; writes to R0 are discarded.
- Operand read in ID uses two bypasses:
  - Write-through: a WB write to the same register in the same cycle supplies the new value.
  - MEM bypass: if the instruction currently in MEM writes the source register, use its result. That is the ALU result, or Mem[ALUOut] for LW.
- No bypass from EX and no stall logic. A dependent instruction must not immediately follow its producer; software inserts one independent instruction between them. This also covers load-use.
- Branches:
  - Resolved in EX.
  - If taken: PC ← target, `TAKEN_BRANCH` pulses 1 for one cycle, and the two younger instructions in IF/ID and ID/EX become bubbles with no writes.
  - Not taken: no effect.
- HLT:
  - Decoding HLT in ID stops fetch; IF inserts bubbles from then on.
  - When HLT reaches WB, `HALTED` ← 1.
  - While `HALTED`=1, PC, pipeline registers, `Reg` and `Mem` are frozen until `rst`.
- Reset:
  - Clears PC, `HALTED`, `TAKEN_BRANCH` and all pipeline valid bits (all stages become bubbles).
  - Does not clear `Reg` or `Mem`.
  - Reset mid-program discards all in-flight instructions and refetches from 0.

## Timing
- Throughput: 1 instruction per cycle with no hazards.
- Latency: IF in cycle n, WB write in cycle n+4.
- An SW store lands at the end of its MEM cycle, n+3.
- A taken branch costs 2 bubble cycles.
- `halted` rises at the end of HLT's WB cycle. A 7-instruction straight-line program from PC 0 halts within 12 cycles of reset release.

## Structure
- A shared package `mips32_pkg` holds:
  - Opcode constants.
  - Instruction-type enum: RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP.
  - Pipeline-register struct typedefs (IF/ID, ID/EX, EX/MEM, MEM/WB, each with a valid bit and type).
- One natural sub-module: `mips32_alu`, combinational, taking op, A and B and producing the result and zero flag.
- The remaining logic (register file, memory, stage registers, bypass, flush and halt control) stays in the top module.

## Test plan
- Load/store program:
  - Preload Reg[k]=k and Mem[120]=85, then pulse rst.
  - Program: ADDI R1,R0,120; OR R3,R3,R3; LW R2,0(R1); OR R3,R3,R3; ADDI R2,R2,45; OR R3,R3,R3; SW R2,1(R1); HLT.
  - Required: Mem[121]=130, Mem[120]=85, R1=120, R2=130, `halted`=1.
- RR ALU, with Reg[k]=k:
  - ADD R10,R1,R2 → 3. SUB R11,R1,R2 → FFFFFFFF. MUL R12,R5,R6 → 30. SLT R13,R11,R1 → 1. AND R14,R7,R3 → 3.
- Branches:
  - BEQZ R0 with imm=2: the two following instructions (ADDI R20,R0,1; ADDI R21,R0,1) are not executed, R20 and R21 keep their preloaded values, and the target executes.
  - BNEQZ R0: falls through.
- Halt:
  - An SW placed after HLT does not change memory.
  - PC and Reg stay frozen for 20 cycles after `halted`=1.
- Reset mid-program:
  - Assert rst during the LW program, then release.
  - Required: `halted`=0, and the full program reruns from PC 0 with the same final values.
- R0 protection: ADDI R0,R0,5 leaves R0=0.
